// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared constants and types for the ROM port arbiter
package rom_port_arbiter_pkg;
  localparam int NUM_CORES = 4;
  localparam int ADDR_W_DEF = 15;
  localparam int TAG_W = 2;
  typedef logic [TAG_W-1:0] core_idx_t;
  typedef struct packed {
    logic      valid;
    core_idx_t core;
  } port_tag_t;
  function automatic core_idx_t onehot_to_idx(input logic [NUM_CORES-1:0] oh);
    core_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CORES; i++) if (oh[i]) idx = core_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: core fetch handshake and ROM port signals of the arbiter
interface rom_port_arbiter_if import rom_port_arbiter_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] rvalid;
  logic [WIDTH-1:0] addr_core0, addr_core1, addr_core2, addr_core3;
  logic [WIDTH-1:0] data_core0, data_core1, data_core2, data_core3;
  logic [ADDR_W-1:0] rom_address_a, rom_address_b;
  logic [WIDTH-1:0] rom_q_a, rom_q_b;
  modport master (
    output req, addr_core0, addr_core1, addr_core2, addr_core3, rom_q_a, rom_q_b,
    input  gnt, rvalid, data_core0, data_core1, data_core2, data_core3, rom_address_a, rom_address_b
  );
  modport slave (
    input  req, addr_core0, addr_core1, addr_core2, addr_core3, rom_q_a, rom_q_b,
    output gnt, rvalid, data_core0, data_core1, data_core2, data_core3, rom_address_a, rom_address_b
  );
endinterface

// File: rtl/rom_port_arbiter_rr_pick2.sv
// rr_pick2: picks up to two requesting cores round-robin from ptr, first one to port A
module rr_pick2 import rom_port_arbiter_pkg::*; (
  input  logic [NUM_CORES-1:0] req,
  input  core_idx_t            ptr,
  output logic [NUM_CORES-1:0] pick_a,
  output logic [NUM_CORES-1:0] pick_b,
  output logic                 valid_a,
  output logic                 valid_b
);
  core_idx_t idx;
  always_comb begin
    pick_a = '0;
    pick_b = '0;
    idx = ptr;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = core_idx_t'(int'(ptr) + i);
      if (req[idx] && pick_a == '0) pick_a[idx] = 1'b1;
      else if (req[idx] && pick_b == '0) pick_b[idx] = 1'b1;
    end
  end
  assign valid_a = |pick_a;
  assign valid_b = |pick_b;
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a dual-port ROM among four cores with fixed two-cycle fetch latency
module rom_port_arbiter import rom_port_arbiter_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst_n,
  rom_port_arbiter_if.slave bus
);
  core_idx_t ptr, idx_a, idx_b;
  logic [NUM_CORES-1:0] pick_a, pick_b, hit_a, hit_b, rvalid_q;
  logic valid_a, valid_b, gnt_a, gnt_b;
  logic [ADDR_W-1:0] addr [NUM_CORES];
  logic [WIDTH-1:0] data [NUM_CORES];
  port_tag_t tag_a, tag_b;
  assign addr = '{bus.addr_core0[ADDR_W-1:0], bus.addr_core1[ADDR_W-1:0],
                  bus.addr_core2[ADDR_W-1:0], bus.addr_core3[ADDR_W-1:0]};
  rr_pick2 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .pick_a (pick_a),
    .pick_b (pick_b),
    .valid_a(valid_a),
    .valid_b(valid_b)
  );
  assign gnt_a = valid_a & rst_n;
  assign gnt_b = valid_b & rst_n;
  assign idx_a = onehot_to_idx(pick_a);
  assign idx_b = onehot_to_idx(pick_b);
  assign bus.gnt = rst_n ? (pick_a | pick_b) : '0;
  assign bus.rom_address_a = gnt_a ? addr[idx_a] : '0;
  assign bus.rom_address_b = gnt_b ? addr[idx_b] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      tag_a <= '0;
      tag_b <= '0;
    end else begin
      if (gnt_a) ptr <= (gnt_b ? idx_b : idx_a) + 1'b1;
      tag_a <= '{valid: gnt_a, core: idx_a};
      tag_b <= '{valid: gnt_b, core: idx_b};
    end
  end
  // ROM data for a tag arrives the cycle after the grant; steer it to the tagged core
  assign hit_a = tag_a.valid ? NUM_CORES'(1) << tag_a.core : '0;
  assign hit_b = tag_b.valid ? NUM_CORES'(1) << tag_b.core : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) data[i] <= '0;
    end else begin
      rvalid_q <= hit_a | hit_b;
      for (int i = 0; i < NUM_CORES; i++)
        if (hit_a[i]) data[i] <= bus.rom_q_a;
        else if (hit_b[i]) data[i] <= bus.rom_q_b;
    end
  end
  assign bus.rvalid = rvalid_q;
  assign bus.data_core0 = data[0];
  assign bus.data_core1 = data[1];
  assign bus.data_core2 = data[2];
  assign bus.data_core3 = data[3];
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed checks of grants, fetch latency, reset and a random handshake run
module tb_rom_port_arbiter;
  localparam int WIDTH = 32;
  localparam int ADDR_W = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  rom_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  rom_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {2'b10, a, ~a};
  endfunction
  always @(posedge clk) begin
    bus.rom_q_a <= rom_word(bus.rom_address_a);
    bus.rom_q_b <= rom_word(bus.rom_address_b);
  end
  function automatic logic [WIDTH-1:0] data_of(input int c);
    case (c)
      0: return bus.data_core0;
      1: return bus.data_core1;
      2: return bus.data_core2;
      default: return bus.data_core3;
    endcase
  endfunction
  task automatic set_addr(input int c, input logic [WIDTH-1:0] v);
    case (c)
      0: bus.addr_core0 = v;
      1: bus.addr_core1 = v;
      2: bus.addr_core2 = v;
      default: bus.addr_core3 = v;
    endcase
  endtask
  task automatic idle();
    bus.req = '0;
    for (int i = 0; i < 4; i++) set_addr(i, '0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_addr(i, 32'd7);
    #2;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL reset rvalid got %b want 0000", bus.rvalid); end
    checks++; if (bus.rom_address_a !== '0) begin errors++; $display("FAIL reset rom_address_a got %0d want 0", bus.rom_address_a); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_of(i) !== '0) begin errors++; $display("FAIL reset data_core%0d got %h want 0", i, data_of(i)); end
    end
  endtask
  task automatic test_single();
    do_reset();
    @(negedge clk);
    bus.req = 4'b0001;
    set_addr(0, 32'd5);
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single gnt got %b want 0001", bus.gnt); end
    checks++; if (bus.rom_address_a !== 15'd5) begin errors++; $display("FAIL single rom_address_a got %0d want 5", bus.rom_address_a); end
    checks++; if (bus.rom_address_b !== 15'd0) begin errors++; $display("FAIL single rom_address_b got %0d want 0", bus.rom_address_b); end
    @(negedge clk);
    bus.req = 4'b0000;
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL single early rvalid got %b want 0000", bus.rvalid); end
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0001) begin errors++; $display("FAIL single rvalid got %b want 0001", bus.rvalid); end
    checks++; if (bus.data_core0 !== rom_word(15'd5)) begin errors++; $display("FAIL single data got %h want %h", bus.data_core0, rom_word(15'd5)); end
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL single pulse rvalid got %b want 0000", bus.rvalid); end
    checks++; if (bus.data_core0 !== rom_word(15'd5)) begin errors++; $display("FAIL single hold got %h want %h", bus.data_core0, rom_word(15'd5)); end
  endtask
  task automatic test_all_four();
    logic [3:0] exp_g, exp_r;
    int base;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.req = k < 4 ? 4'b1111 : 4'b0000;
      for (int i = 0; i < 4; i++) set_addr(i, 32'(100 + 4 * k + i));
      #1;
      exp_g = k < 4 ? (k % 2 == 1 ? 4'b1100 : 4'b0011) : 4'b0000;
      exp_r = (k >= 2 && k < 6) ? (k % 2 == 1 ? 4'b1100 : 4'b0011) : 4'b0000;
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL all4 gnt cyc %0d got %b want %b", k, bus.gnt, exp_g); end
      if (k < 4) begin
        base = 100 + 4 * k + (k % 2 == 1 ? 2 : 0);
        checks++; if (bus.rom_address_a !== ADDR_W'(base)) begin errors++; $display("FAIL all4 addr_a cyc %0d got %0d want %0d", k, bus.rom_address_a, base); end
        checks++; if (bus.rom_address_b !== ADDR_W'(base + 1)) begin errors++; $display("FAIL all4 addr_b cyc %0d got %0d want %0d", k, bus.rom_address_b, base + 1); end
      end
      checks++; if (bus.rvalid !== exp_r) begin errors++; $display("FAIL all4 rvalid cyc %0d got %b want %b", k, bus.rvalid, exp_r); end
      for (int i = 0; i < 4; i++)
        if (exp_r[i]) begin
          checks++;
          if (data_of(i) !== rom_word(ADDR_W'(100 + 4 * (k - 2) + i))) begin
            errors++; $display("FAIL all4 data core%0d cyc %0d got %h want %h", i, k, data_of(i), rom_word(ADDR_W'(100 + 4 * (k - 2) + i)));
          end
        end
    end
  endtask
  task automatic test_ptr_wrap();
    do_reset();
    @(negedge clk);
    bus.req = 4'b0100;
    set_addr(2, 32'd33);
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL wrap single gnt got %b want 0100", bus.gnt); end
    checks++; if (bus.rom_address_a !== 15'd33) begin errors++; $display("FAIL wrap single addr_a got %0d want 33", bus.rom_address_a); end
    checks++; if (bus.rom_address_b !== 15'd0) begin errors++; $display("FAIL wrap single addr_b got %0d want 0", bus.rom_address_b); end
    @(negedge clk);
    bus.req = 4'b1001;
    set_addr(3, 32'd44);
    set_addr(0, 32'd55);
    #1;
    checks++; if (bus.gnt !== 4'b1001) begin errors++; $display("FAIL wrap gnt got %b want 1001", bus.gnt); end
    checks++; if (bus.rom_address_a !== 15'd44) begin errors++; $display("FAIL wrap addr_a got %0d want 44", bus.rom_address_a); end
    checks++; if (bus.rom_address_b !== 15'd55) begin errors++; $display("FAIL wrap addr_b got %0d want 55", bus.rom_address_b); end
    @(negedge clk);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_addr(i, 32'(60 + i));
    #1;
    checks++; if (bus.gnt !== 4'b0110) begin errors++; $display("FAIL wrap ptr1 gnt got %b want 0110", bus.gnt); end
    checks++; if (bus.rvalid !== 4'b0100) begin errors++; $display("FAIL wrap rvalid2 got %b want 0100", bus.rvalid); end
    checks++; if (bus.data_core2 !== rom_word(15'd33)) begin errors++; $display("FAIL wrap data2 got %h want %h", bus.data_core2, rom_word(15'd33)); end
    @(negedge clk);
    bus.req = 4'b0000;
    checks++; if (bus.rvalid !== 4'b1001) begin errors++; $display("FAIL wrap rvalid30 got %b want 1001", bus.rvalid); end
    checks++; if (bus.data_core3 !== rom_word(15'd44)) begin errors++; $display("FAIL wrap data3 got %h want %h", bus.data_core3, rom_word(15'd44)); end
    checks++; if (bus.data_core0 !== rom_word(15'd55)) begin errors++; $display("FAIL wrap data0 got %h want %h", bus.data_core0, rom_word(15'd55)); end
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0110) begin errors++; $display("FAIL wrap rvalid12 got %b want 0110", bus.rvalid); end
    checks++; if (bus.data_core1 !== rom_word(15'd61)) begin errors++; $display("FAIL wrap data1 got %h want %h", bus.data_core1, rom_word(15'd61)); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    bus.req = 4'b0010;
    set_addr(1, 32'd77);
    #1;
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rstmid gnt got %b want 0010", bus.gnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rstmid gnt in reset got %b want 0000", bus.gnt); end
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rstmid rvalid in reset got %b want 0000", bus.rvalid); end
    checks++; if (bus.rom_address_a !== '0) begin errors++; $display("FAIL rstmid addr_a in reset got %0d want 0", bus.rom_address_a); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_of(i) !== '0) begin errors++; $display("FAIL rstmid data_core%0d got %h want 0", i, data_of(i)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_addr(i, 32'(80 + i));
    #1;
    checks++; if (bus.gnt !== 4'b0011) begin errors++; $display("FAIL rstmid release gnt got %b want 0011", bus.gnt); end
    @(negedge clk);
    bus.req = 4'b0000;
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rstmid stale rvalid got %b want 0000", bus.rvalid); end
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0011) begin errors++; $display("FAIL rstmid rvalid got %b want 0011", bus.rvalid); end
    checks++; if (bus.data_core1 !== rom_word(15'd81)) begin errors++; $display("FAIL rstmid data1 got %h want %h", bus.data_core1, rom_word(15'd81)); end
    @(negedge clk);
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL rstmid tail rvalid got %b want 0000", bus.rvalid); end
  endtask
  task automatic test_random();
    logic [3:0] rq, g, g1, g2;
    logic [WIDTH-1:0] ad [4];
    logic [WIDTH-1:0] d1 [4];
    logic [WIDTH-1:0] d2 [4];
    int wait_c [4];
    do_reset();
    rq = '0; g1 = '0; g2 = '0;
    for (int i = 0; i < 4; i++) begin ad[i] = '0; d1[i] = '0; d2[i] = '0; wait_c[i] = 0; end
    for (int cyc = 0; cyc < 10002; cyc++) begin
      @(negedge clk);
      checks++; if (bus.rvalid !== g2) begin errors++; $display("FAIL rand rvalid cyc %0d got %b want %b", cyc, bus.rvalid, g2); end
      for (int i = 0; i < 4; i++)
        if (g2[i]) begin
          checks++; if (data_of(i) !== d2[i]) begin errors++; $display("FAIL rand data core%0d cyc %0d got %h want %h", i, cyc, data_of(i), d2[i]); end
        end
      g2 = g1;
      d2 = d1;
      for (int i = 0; i < 4; i++)
        if (cyc >= 10000) rq[i] = 1'b0;
        else if (!rq[i] || g1[i]) begin
          rq[i] = $urandom_range(0, 2) != 0;
          ad[i] = $urandom;
        end
      bus.req = rq;
      for (int i = 0; i < 4; i++) set_addr(i, ad[i]);
      #1;
      g = bus.gnt;
      checks++; if ((g & ~rq) !== 4'b0000 || $countones(g) > 2) begin errors++; $display("FAIL rand gnt cyc %0d got %b req %b", cyc, g, rq); end
      for (int i = 0; i < 4; i++) begin
        wait_c[i] = (rq[i] && !g[i]) ? wait_c[i] + 1 : 0;
        checks++; if (wait_c[i] >= 2) begin errors++; $display("FAIL rand starve core%0d cyc %0d waited %0d want <2", i, cyc, wait_c[i]); end
        d1[i] = rom_word(ad[i][ADDR_W-1:0]);
      end
      g1 = g;
    end
  endtask
  initial begin
    bus.rom_q_a = '0;
    bus.rom_q_b = '0;
    test_reset();
    test_single();
    test_all_four();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, instruction data width.
REQ-002 Parameter ADDR_W, default 15, ROM word-address width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req[3:0]  input  4  per-core fetch request; bit i = core i.
REQ-006 Port addr_core0..addr_core3  input  WIDTH each  per-core fetch address; only bits [ADDR_W-1:0] used.
REQ-007 Port gnt[3:0]  output  4  per-core grant, combinational, same cycle as req.
REQ-008 Port rvalid[3:0]  output  4  per-core one-cycle data-valid pulse, registered.
REQ-009 Port data_core0..data_core3  output  WIDTH each  per-core fetched word, registered.
REQ-010 Port rom_address_a, rom_address_b  output  ADDR_W each  to the two ROM ports.
REQ-011 Port rom_q_a, rom_q_b  input  WIDTH each  ROM read data, valid one cycle after address is sampled.

Function
REQ-012 The block SHALL share one dual-port synchronous ROM (ports A, B) among four cores; at most two grants per cycle.
REQ-013 Selection: scan cores starting at round-robin pointer ptr (2 bits), ascending mod 4; first requesting core gets port A, second gets port B.
REQ-014 With 0 requests: no grant, ptr unchanged; 1 request: port A only, port B idle.
REQ-015 ptr SHALL update to (index of last granted core + 1) mod 4 on each cycle with at least one grant.
REQ-016 rom_address_a/b SHALL carry the granted core's addr[ADDR_W-1:0] in the grant cycle; idle port drives 0.
REQ-017 Handshake: core holds req and addr stable until gnt seen; req with gnt high counts as one accepted fetch; core may re-request next cycle.
REQ-018 Tag pipeline: per port, register {valid, core index} at grant edge.
REQ-019 In cycle N+1 after grant cycle N, the tagged core's data_coreX SHALL load rom_q of its port at the end of N+1; rvalid[X] high for exactly cycle N+2.
REQ-020 Fixed latency: grant cycle N -> rvalid in N+2, independent of contention; fully pipelined, back-to-back grants yield back-to-back rvalid.
REQ-021 data_coreX SHALL hold last loaded value when rvalid[X] low.
REQ-022 A core SHALL never be granted both ports in one cycle.
REQ-023 Starvation bound: a continuously requesting core is granted within 2 cycles.
REQ-024 gnt SHALL be 0 for cores with req low; gnt SHALL be 0 while rst_n low.

Reset
REQ-025 On rst_n low: ptr=0, tag valids=0, rvalid=0, data_core0..3=0, immediately (asynchronous).
REQ-026 Reset mid-operation SHALL discard in-flight fetches; no rvalid for them after release.
REQ-027 First cycle after release SHALL arbitrate normally from ptr=0.

Structure
REQ-028 Shared package SHALL hold NUM_CORES=4, ADDR_W default, tag width (2), and the port tag record type.
REQ-029 One combinational sub-module rr_pick2 (req[3:0], ptr -> two one-hot picks plus valids) SHALL implement REQ-013..014; pipeline and data registers stay in the top.

Verification
REQ-030 Reset, req=4'b0001, addr_core0=5 -> gnt=0001, rom_address_a=5; ROM word 5 appears on data_core0 with rvalid[0] two cycles later.
REQ-031 req=4'b1111 held 4 cycles from ptr=0 -> grants {0,1},{2,3},{0,1},{2,3}; eight rvalid pulses, each two cycles after its grant, correct words.
REQ-032 ptr=3, req=4'b1001 -> core3 on port A, core0 on port B; ptr becomes 1.
REQ-033 req=4'b0100 single request -> port A to core2, rom_address_b=0, no rvalid for other cores.
REQ-034 Assert rst_n low one cycle after grant to core1 -> no rvalid[1] ever, all outputs 0, ptr=0 after release.
REQ-035 Random req over 10k cycles with ROM model -> no core waits more than 2 cycles, every grant yields exactly one rvalid with correct data.
